frame_buffer_rx: RTL and testbench

Double-buffered vector-frame receiver, successor to the single-format UART point buffer. It consumes a decoded byte stream (valid/data, e.g. from uart_rx) and hunts for a sync preamble. It then assembles big-endian 32-bit point words, writes them into the back buffer and swaps buffers only at a drawing-pass boundary. Widths, depth, preamble length and brightness resolution are parametrised, and it adds a receive timeout, overflow handling and frame statistics.

---
 rtl/vector_pkg.sv | 17 +
 rtl/point_ram.sv | 32 +++
 rtl/frame_buffer_rx.sv | 190 +++++++++++++++++++
 tb/tb_frame_buffer_rx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared constants and FSM encoding for the vector-frame receiver.
// Point words are big-endian: {ctrl[31:30], bright[29:24], x[23:12], y[11:0]}.
package vector_pkg;

    localparam logic [31:0] END_MARKER = 32'h0101_0101;

    localparam int Y_LSB      = 0;
    localparam int X_LSB      = 12;
    localparam int BRIGHT_LSB = 24;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        RECEIVE = 2'd1,
        HOLD    = 2'd2
    } rx_state_t;

endpackage

// File: rtl/point_ram.sv
// Single-port point store with a registered read port.
// The read register clears on reset so the frame output starts at zero.
module point_ram #(
    parameter int DEPTH  = 2000,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/frame_buffer_rx.sv
// Double-buffered vector-frame receiver: hunts a zero preamble, assembles
// 32-bit point words into the back RAM and swaps RAMs on a drawing-pass boundary.
module frame_buffer_rx
    import vector_pkg::*;
#(
    parameter int DEPTH    = 2000,
    parameter int ADDR_W   = 11,
    parameter int BRIGHT_W = 1,
    parameter int SYNC_LEN = 8,
    parameter int TIMEOUT  = 100000,
    localparam int POINT_W = 24 + BRIGHT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    input  logic               done_drawing,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [POINT_W-1:0] rd_data,
    output logic [ADDR_W-1:0]  num_points,
    output logic               frame_valid,
    output logic               swap,
    output logic               overflow,
    output logic [15:0]        frames_ok,
    output logic [15:0]        frames_dropped,
    output rx_state_t          state_dbg
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]      SYNC_LAST = 4'(SYNC_LEN - 1);

    rx_state_t state, next_state;

    logic [3:0]         zero_cnt;
    logic [1:0]         byte_idx;
    logic [23:0]        word_sr;
    logic [ADDR_W:0]    wr_ptr;
    logic [ADDR_W-1:0]  back_count;
    logic [TO_W-1:0]    to_cnt;
    logic               back_sel;
    logic               rd_sel_q;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [POINT_W-1:0] wr_data;

    logic [31:0]         full_word;
    logic [BRIGHT_W-1:0] bright;
    logic                sync_hit, word_done, is_end, store_point, timed_out, do_swap;

    assign full_word = {word_sr, rx_data};

    generate
        if (BRIGHT_W == 1) begin : g_bright_flag
            assign bright = |full_word[BRIGHT_LSB +: 6];
        end else begin : g_bright_level
            assign bright = full_word[BRIGHT_LSB + 5 -: BRIGHT_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            HUNT:    if (sync_hit) next_state = RECEIVE;
            RECEIVE: if (is_end) next_state = HOLD;
                     else if (timed_out) next_state = HUNT;
            HOLD:    if (do_swap) next_state = HUNT;
            default: next_state = HUNT;
        endcase
    end

    // rx_valid is a one-cycle byte strobe with no backpressure: every strobed
    // byte is consumed in the cycle it is presented, whatever the state.
    always_comb begin
        sync_hit    = (state == HUNT) && rx_valid && (rx_data == 8'd0) && (zero_cnt == SYNC_LAST);
        word_done   = (state == RECEIVE) && rx_valid && (byte_idx == 2'd3);
        is_end      = word_done && (full_word == END_MARKER);
        store_point = word_done && !is_end;
        timed_out   = (state == RECEIVE) && !rx_valid && (to_cnt == TO_LAST);
        do_swap     = (state == HOLD) && (!frame_valid || done_drawing);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_cnt       <= '0;
            byte_idx       <= '0;
            word_sr        <= '0;
            wr_ptr         <= '0;
            back_count     <= '0;
            to_cnt         <= '0;
            back_sel       <= 1'b0;
            rd_sel_q       <= 1'b0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            num_points     <= '0;
            frame_valid    <= 1'b0;
            swap           <= 1'b0;
            overflow       <= 1'b0;
            frames_ok      <= '0;
            frames_dropped <= '0;
        end else begin
            wr_en    <= 1'b0;
            swap     <= 1'b0;
            rd_sel_q <= back_sel;

            if (state == HUNT && rx_valid) begin
                zero_cnt <= (sync_hit || rx_data != 8'd0) ? 4'd0 : zero_cnt + 4'd1;
            end

            if (sync_hit) begin
                wr_ptr   <= '0;
                byte_idx <= '0;
                to_cnt   <= '0;
                overflow <= 1'b0;
            end

            if (state == RECEIVE) begin
                if (rx_valid) begin
                    to_cnt   <= '0;
                    byte_idx <= byte_idx + 2'd1;
                    word_sr  <= full_word[23:0];
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                // The RAM write lands one cycle after the last byte of the point.
                if (store_point) begin
                    if (wr_ptr < DEPTH_C) begin
                        wr_en   <= 1'b1;
                        wr_addr <= wr_ptr[ADDR_W-1:0];
                        wr_data <= {bright, full_word[X_LSB +: 12], full_word[Y_LSB +: 12]};
                        wr_ptr  <= wr_ptr + 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                if (is_end) begin
                    back_count <= wr_ptr[ADDR_W-1:0];
                end
                if (timed_out) begin
                    frames_dropped <= frames_dropped + 16'd1;
                end
            end

            if (do_swap) begin
                back_sel    <= ~back_sel;
                num_points  <= back_count;
                frame_valid <= 1'b1;
                swap        <= 1'b1;
                frames_ok   <= frames_ok + 16'd1;
            end
        end
    end

    logic [POINT_W-1:0] ram0_q, ram1_q;

    // back_sel == 0 means RAM 0 is the back buffer; the front RAM only ever sees rd_addr.
    point_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(POINT_W)) u_ram0 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && !back_sel),
        .addr  (back_sel ? rd_addr : wr_addr),
        .wdata (wr_data),
        .rdata (ram0_q)
    );

    point_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(POINT_W)) u_ram1 (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en && back_sel),
        .addr  (back_sel ? wr_addr : rd_addr),
        .wdata (wr_data),
        .rdata (ram1_q)
    );

    // The select is delayed to match the RAM read latency, so a read issued on
    // the swap cycle still returns the old front frame.
    assign rd_data   = rd_sel_q ? ram0_q : ram1_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_frame_buffer_rx.sv
// Randomized frame-level bench for frame_buffer_rx against a queue-based model
// of committed frames, counters and the pass-boundary swap rule.
module tb_frame_buffer_rx;
    import vector_pkg::*;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 3;
    localparam int BRIGHT_W = 1;
    localparam int SYNC_LEN = 8;
    localparam int TIMEOUT  = 50;
    localparam int POINT_W  = 24 + BRIGHT_W;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               rx_valid = 1'b0;
    logic [7:0]         rx_data = 8'd0;
    logic               done_drawing = 1'b0;
    logic [ADDR_W-1:0]  rd_addr = '0;
    logic [POINT_W-1:0] rd_data;
    logic [ADDR_W-1:0]  num_points;
    logic               frame_valid;
    logic               swap;
    logic               overflow;
    logic [15:0]        frames_ok;
    logic [15:0]        frames_dropped;
    rx_state_t          state_dbg;

    frame_buffer_rx #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BRIGHT_W(BRIGHT_W),
        .SYNC_LEN(SYNC_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .done_drawing   (done_drawing),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .num_points     (num_points),
        .frame_valid    (frame_valid),
        .swap           (swap),
        .overflow       (overflow),
        .frames_ok      (frames_ok),
        .frames_dropped (frames_dropped),
        .state_dbg      (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [POINT_W-1:0] front_q[$];
    logic [31:0]        tx_words[$];
    bit fv_m   = 1'b0;
    bit ovf_m  = 1'b0;
    int fok_m  = 0;
    int fdrop_m = 0;
    int swaps_m = 0;
    int swap_seen = 0;

    always @(negedge clk) if (swap === 1'b1) swap_seen++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [POINT_W-1:0] exp_point(input logic [31:0] w);
        logic b;
        b = ((w >> 24) & 32'h3F) != 0;
        return {b, w[23:0]};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit dd = 1'b0);
        rx_valid     = 1'b1;
        rx_data      = b;
        done_drawing = dd;
        tick();
        rx_valid     = 1'b0;
        done_drawing = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], $urandom_range(0, 2));
    endtask

    task automatic send_preamble();
        for (int i = 0; i < SYNC_LEN; i++) send_byte(8'h00, $urandom_range(0, 2));
    endtask

    // Noise that never contains a full preamble and always ends on a nonzero byte.
    task automatic send_garbage();
        int n;
        int run;
        logic [7:0] b;
        n = $urandom_range(0, 6);
        run = 0;
        for (int i = 0; i < n; i++) begin
            if (run < SYNC_LEN - 2 && $urandom_range(0, 2) == 0) b = 8'h00;
            else b = 8'($urandom_range(1, 255));
            if (i == n - 1) b = 8'($urandom_range(1, 255));
            run = (b == 8'h00) ? run + 1 : 0;
            send_byte(b, $urandom_range(0, 2));
        end
    endtask

    function automatic logic [31:0] rand_point();
        logic [31:0] w;
        w = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
        if (w == END_MARKER) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic check_all();
        check_eq("num_points", 32'(num_points), 32'(front_q.size()));
        check_eq("frame_valid", 32'(frame_valid), 32'(fv_m));
        check_eq("overflow", 32'(overflow), 32'(ovf_m));
        check_eq("frames_ok", 32'(frames_ok), 32'(fok_m % 65536));
        check_eq("frames_dropped", 32'(frames_dropped), 32'(fdrop_m % 65536));
        check_eq("swap_count", 32'(swap_seen), 32'(swaps_m));
        for (int i = 0; i < front_q.size(); i++) begin
            rd_addr = ADDR_W'(i);
            tick();
            check_eq("rd_data", 32'(rd_data), 32'(front_q[i]));
        end
    endtask

    // Sends tx_words as one frame and applies the commit / pass-boundary rules.
    task automatic run_frame(input bit with_garbage);
        logic [POINT_W-1:0] trunc[$];
        bit dd_end;
        int k;
        if (with_garbage) send_garbage();
        send_preamble();
        foreach (tx_words[i]) begin
            send_word(tx_words[i]);
            if (i < DEPTH) trunc.push_back(exp_point(tx_words[i]));
        end
        for (int i = 0; i < 3; i++) send_byte(8'h01, $urandom_range(0, 2));
        dd_end = fv_m && ($urandom_range(0, 1) == 1);
        send_byte(8'h01, 0, dd_end);
        ovf_m = tx_words.size() > DEPTH;
        if (!fv_m) begin
            k = 0;
            while (swap_seen == swaps_m && k < 10) begin
                tick();
                k++;
            end
            check_eq("swap_wait", 32'(swap_seen), 32'(swaps_m + 1));
        end else begin
            k = $urandom_range(0, 3);
            repeat (k) send_byte(8'($urandom), 0);
            repeat (2) tick();
            check_eq("hold_noswap", 32'(swap_seen), 32'(swaps_m));
            check_eq("hold_frames_ok", 32'(frames_ok), 32'(fok_m % 65536));
            rd_addr = '0;
            tick();
            if (front_q.size() > 0) check_eq("hold_rd_old", 32'(rd_data), 32'(front_q[0]));
            done_drawing = 1'b1;
            tick();
            done_drawing = 1'b0;
            check_eq("swap_pulse", 32'(swap), 32'd1);
            if (front_q.size() > 0) check_eq("swap_rd_old", 32'(rd_data), 32'(front_q[0]));
            tick();
        end
        swaps_m++;
        fok_m++;
        fv_m = 1'b1;
        front_q = trunc;
        check_all();
    endtask

    task automatic run_timeout();
        int k;
        send_garbage();
        send_preamble();
        k = $urandom_range(1, 7);
        for (int i = 0; i < k; i++) send_byte(8'($urandom_range(2, 255)), (i == k - 1) ? 0 : $urandom_range(0, 2));
        repeat (TIMEOUT - 5) tick();
        check_eq("to_early_dropped", 32'(frames_dropped), 32'(fdrop_m % 65536));
        check_eq("to_early_state", 32'(state_dbg), 32'(RECEIVE));
        repeat (10) tick();
        fdrop_m++;
        ovf_m = 1'b0;
        check_eq("to_state", 32'(state_dbg), 32'(HUNT));
        check_all();
    endtask

    task automatic run_reset();
        send_garbage();
        send_preamble();
        repeat ($urandom_range(1, 6)) send_byte(8'($urandom), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rst_num_points", 32'(num_points), 32'd0);
        check_eq("rst_frame_valid", 32'(frame_valid), 32'd0);
        check_eq("rst_swap", 32'(swap), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_frames_ok", 32'(frames_ok), 32'd0);
        check_eq("rst_frames_dropped", 32'(frames_dropped), 32'd0);
        check_eq("rst_rd_data", 32'(rd_data), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(HUNT));
        front_q.delete();
        fv_m = 1'b0;
        ovf_m = 1'b0;
        fok_m = 0;
        fdrop_m = 0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int sel;
        repeat (3) tick();
        check_eq("init_num_points", 32'(num_points), 32'd0);
        check_eq("init_frame_valid", 32'(frame_valid), 32'd0);
        check_eq("init_overflow", 32'(overflow), 32'd0);
        check_eq("init_frames_ok", 32'(frames_ok), 32'd0);
        check_eq("init_rd_data", 32'(rd_data), 32'd0);
        check_eq("init_state", 32'(state_dbg), 32'(HUNT));
        reset = 1'b0;
        tick();

        // Frame load, hand-derived packed points.
        tx_words = '{32'h0012_3456, 32'h3FFF_F000};
        run_frame(1'b0);
        rd_addr = 3'd0;
        tick();
        check_eq("load_pt0", 32'(rd_data), 32'h0123456);
        rd_addr = 3'd1;
        tick();
        check_eq("load_pt1", 32'(rd_data), 32'h1FFF000);

        // Broken preamble followed by a real one; frame waits for done_drawing.
        for (int i = 0; i < 5; i++) send_byte(8'h00, 0);
        send_byte(8'h07, 0);
        tx_words = '{rand_point()};
        run_frame(1'b0);

        // Overflow at DEPTH.
        tx_words.delete();
        for (int i = 0; i < 6; i++) tx_words.push_back(rand_point());
        run_frame(1'b1);

        run_timeout();
        run_reset();
        tx_words = '{rand_point(), rand_point(), rand_point()};
        run_frame(1'b1);

        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 19);
            if (sel < 15) begin
                tx_words.delete();
                repeat ($urandom_range(0, 6)) tx_words.push_back(rand_point());
                run_frame(1'b1);
            end else if (sel < 18) begin
                run_timeout();
            end else begin
                run_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
